// File: rtl/pipe_trace_buffer_if.sv
// Output port bundle of the pipeline trace buffer: head-record valid/ready
// handshake plus the 72-bit record itself.
interface pipe_trace_buffer_if;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/pipe_trace_buffer.sv
// Triggered pipeline trace buffer: snapshots fetch/ID info into a FIFO after
// pc hits trig_pc. Define TRACE_DEDUP_EN to collapse repeated stall samples.
module pipe_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          pc,
  input  logic [31:0]          inst,
  input  logic [1:0]           adep,
  input  logic [1:0]           bdep,
  input  logic                 loaddep,
  input  logic                 btaken,
  input  logic                 arm,
  input  logic [31:0]          trig_pc,
  input  logic                 stop,
  pipe_trace_buffer_if.master  trace,
  output logic [1:0]           state,
  output logic [PTR_W:0]       count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);

  state_t           cur_state, next_state;
  logic [71:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cap_cnt;
  logic [PTR_W:0]   count_after_wr;
  logic [71:0]      sample;
  logic             wr_en, pop, room, dup, cap_load, cap_inc;

  assign sample          = {pc, inst, adep, bdep, loaddep, btaken, 2'b00};
  assign pop             = trace.out_valid && trace.out_ready;
  assign room            = (count != FULL) || pop;
  assign count_after_wr  = count + ONE - (PTR_W+1)'(pop);
  assign trace.out_valid = (count != '0);
  assign trace.out_data  = mem[rd_ptr];
  assign state           = cur_state;

`ifdef TRACE_DEDUP_EN
  logic [31:0] last_pc, last_inst;
  logic        last_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_pc   <= '0;
      last_inst <= '0;
      last_ok   <= 1'b0;
    end else if (wr_en) begin
      last_pc   <= pc;
      last_inst <= inst;
      last_ok   <= 1'b1;
    end
  end

  assign dup = (cur_state == CAPTURE) && last_ok && (pc == last_pc) && (inst == last_inst);
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= next_state;
  end

  // A capture ends after DEPTH writes or once the FIFO fills, whichever comes first.
  always_comb begin
    next_state = cur_state;
    wr_en      = 1'b0;
    cap_load   = 1'b0;
    cap_inc    = 1'b0;
    case (cur_state)
      IDLE: begin
        if (arm) next_state = ARMED;
      end
      ARMED: begin
        if (!arm) begin
          next_state = IDLE;
        end else if (pc == trig_pc) begin
          if (room) begin
            wr_en      = 1'b1;
            cap_load   = 1'b1;
            next_state = (count_after_wr == FULL) ? DONE : CAPTURE;
          end else begin
            next_state = DONE;
          end
        end
      end
      CAPTURE: begin
        if (stop || !room) begin
          next_state = DONE;
        end else if (!dup) begin
          wr_en   = 1'b1;
          cap_inc = 1'b1;
          if ((cap_cnt + ONE == FULL) || (count_after_wr == FULL)) next_state = DONE;
        end
      end
      DONE: begin
        if ((count == '0) && !arm) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cap_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (cap_load)     cap_cnt <= ONE;
      else if (cap_inc) cap_cnt <= cap_cnt + ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= sample;
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Scoreboard bench for pipe_trace_buffer: directed captures push expected
// records, a negedge monitor pops and compares every accepted head record.
module tb_pipe_trace_buffer;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
`ifdef TRACE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      pc = '0, inst = '0, trig_pc = 32'h0000_0008;
  logic [1:0]       adep = '0, bdep = '0;
  logic             loaddep = 1'b0, btaken = 1'b0, arm = 1'b0, stop = 1'b0;
  logic [1:0]       dut_state;
  logic [PTR_W:0]   count;

  int               compared = 0;
  int               mismatched = 0;
  int               pops = 0;
  logic [71:0]      exp_q[$];
  logic [71:0]      mon_exp;

  pipe_trace_buffer_if trace_bus ();

  pipe_trace_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .pc      (pc),
    .inst    (inst),
    .adep    (adep),
    .bdep    (bdep),
    .loaddep (loaddep),
    .btaken  (btaken),
    .arm     (arm),
    .trig_pc (trig_pc),
    .stop    (stop),
    .trace   (trace_bus),
    .state   (dut_state),
    .count   (count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return {p[15:0], ~p[15:0]};
  endfunction

  function automatic logic [71:0] rec(input logic [31:0] p, input logic ld);
    return {p, inst_of(p), 2'b01, 2'b10, ld, p[2], 2'b00};
  endfunction

  task automatic apply_stimulus(input logic [31:0] p, input logic ld, input logic s);
    pc      = p;
    inst    = inst_of(p);
    adep    = 2'b01;
    bdep    = 2'b10;
    loaddep = ld;
    btaken  = p[2];
    stop    = s;
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input int unsigned act, input int unsigned exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every head record the host accepts must be the oldest expected one.
  always @(negedge clock) begin
    if (!reset && trace_bus.out_valid && trace_bus.out_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_record: got 0x%0h, expected none", trace_bus.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        pops++;
        if (trace_bus.out_data !== mon_exp) begin
          mismatched++;
          $display("[TB] FAIL record: got 0x%0h, expected 0x%0h", trace_bus.out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] seq_pc[$];
    logic        seq_ld[$];
    logic [31:0] last_p;
    int          max_cnt;
    int          pops_before;
    int          nwr;
    bit          started;

    trace_bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_output("reset_state", 32'(dut_state), 0);
    check_output("reset_count", 32'(count), 0);
    check_output("reset_valid", 32'(trace_bus.out_valid), 0);

    // Full capture with host stalled: records 0x8..0x44 held.
    arm = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k >= 2 && k <= 17) exp_q.push_back(rec(32'(4 * k), 1'b0));
      apply_stimulus(32'(4 * k), 1'b0, 1'b0);
      if (k == 0) check_output("armed", 32'(dut_state), 1);
      if (k == 1) check_output("no_write_before_trig", 32'(count), 0);
      if (k == 2) begin
        check_output("capture", 32'(dut_state), 2);
        check_output("first_valid", 32'(trace_bus.out_valid), 1);
        check_output("first_count", 32'(count), 1);
      end
      if (k == 10) check_output("head_stable", 32'(trace_bus.out_data[71:40]), 32'h8);
      if (k == 17) check_output("done", 32'(dut_state), 3);
    end
    check_output("full_count", 32'(count), 16);

    // Drain with arm still high: DONE must hold at empty.
    trace_bus.out_ready = 1'b1;
    repeat (16) apply_stimulus(32'h100, 1'b0, 1'b0);
    check_output("drained_count", 32'(count), 0);
    check_output("drained_valid", 32'(trace_bus.out_valid), 0);
    check_output("done_hold_arm", 32'(dut_state), 3);
    check_output("queue_empty_1", 32'(exp_q.size()), 0);
    arm = 1'b0;
    apply_stimulus(32'h100, 1'b0, 1'b0);
    check_output("idle_after_drain", 32'(dut_state), 0);
    check_output("ready_no_effect", 32'(count), 0);

    // Capture while the host pops every cycle.
    arm = 1'b1;
    max_cnt = 0;
    pops_before = pops;
    for (int k = 0; k <= 20; k++) begin
      if (k >= 2 && k <= 17) exp_q.push_back(rec(32'(4 * k), 1'b0));
      apply_stimulus(32'(4 * k), 1'b0, 1'b0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (k == 17) check_output("stream_done", 32'(dut_state), 3);
    end
    check_output("stream_max_count", 32'(max_cnt), 1);
    check_output("stream_count", 32'(count), 0);
    arm = 1'b0;
    apply_stimulus(32'h100, 1'b0, 1'b0);
    check_output("stream_idle", 32'(dut_state), 0);
    check_output("stream_pops", 32'(pops - pops_before), 16);

    // Early stop on the fourth capture cycle.
    trace_bus.out_ready = 1'b0;
    arm = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      if (k >= 2 && k <= 5) exp_q.push_back(rec(32'(4 * k), 1'b0));
      apply_stimulus(32'(4 * k), 1'b0, k == 6);
      if (k == 6) check_output("stop_done", 32'(dut_state), 3);
    end
    check_output("stop_count", 32'(count), 4);
    trace_bus.out_ready = 1'b1;
    arm = 1'b0;
    repeat (5) apply_stimulus(32'h200, 1'b0, 1'b0);
    check_output("stop_idle", 32'(dut_state), 0);
    check_output("queue_empty_2", 32'(exp_q.size()), 0);

    // Load-use stall: pc 0x10 repeated three cycles.
    for (int k = 0; k <= 4; k++) begin seq_pc.push_back(32'(4 * k)); seq_ld.push_back(1'b0); end
    repeat (2) begin seq_pc.push_back(32'h10); seq_ld.push_back(1'b1); end
    seq_ld[4] = 1'b1;
    for (int k = 5; k <= 24; k++) begin seq_pc.push_back(32'(4 * k)); seq_ld.push_back(1'b0); end
    started = 1'b0;
    nwr = 0;
    last_p = '0;
    foreach (seq_pc[i]) begin
      if (!started) begin
        if (seq_pc[i] == 32'h8 && i > 0) begin
          started = 1'b1;
          nwr = 1;
          last_p = seq_pc[i];
          exp_q.push_back(rec(seq_pc[i], seq_ld[i]));
        end
      end else if (nwr < DEPTH && !(DEDUP && seq_pc[i] == last_p)) begin
        nwr++;
        last_p = seq_pc[i];
        exp_q.push_back(rec(seq_pc[i], seq_ld[i]));
      end
    end
    trace_bus.out_ready = 1'b0;
    arm = 1'b1;
    foreach (seq_pc[i]) apply_stimulus(seq_pc[i], seq_ld[i], 1'b0);
    check_output("stall_count", 32'(count), 16);
    check_output("stall_done", 32'(dut_state), 3);
    trace_bus.out_ready = 1'b1;
    arm = 1'b0;
    repeat (17) apply_stimulus(32'h300, 1'b0, 1'b0);
    check_output("stall_idle", 32'(dut_state), 0);
    check_output("queue_empty_3", 32'(exp_q.size()), 0);

    // Asynchronous reset with nine records held mid-capture.
    trace_bus.out_ready = 1'b0;
    arm = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k >= 2) exp_q.push_back(rec(32'(4 * k), 1'b0));
      apply_stimulus(32'(4 * k), 1'b0, 1'b0);
    end
    check_output("pre_reset_count", 32'(count), 9);
    #2 reset = 1'b1;
    #1;
    check_output("async_reset_state", 32'(dut_state), 0);
    check_output("async_reset_count", 32'(count), 0);
    check_output("async_reset_valid", 32'(trace_bus.out_valid), 0);
    exp_q.delete();
    #2 reset = 1'b0;

    // Clean restart after reset.
    for (int k = 0; k <= 6; k++) begin
      if (k >= 2 && k <= 5) exp_q.push_back(rec(32'(4 * k), 1'b0));
      apply_stimulus(32'(4 * k), 1'b0, k == 6);
    end
    check_output("restart_count", 32'(count), 4);
    check_output("restart_done", 32'(dut_state), 3);
    trace_bus.out_ready = 1'b1;
    arm = 1'b0;
    repeat (5) apply_stimulus(32'h400, 1'b0, 1'b0);
    check_output("restart_idle", 32'(dut_state), 0);
    check_output("queue_empty_4", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pipe_trace_buffer.md
PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of trace records stored; SHALL be a power of two, 4 to 256.
REQ-002 Parameter PTR_W, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc  input  32  CPU fetch PC, sampled every cycle.
REQ-006 inst  input  32  CPU fetched instruction, sampled with pc.
REQ-007 adep  input  2  ID-stage A-operand forwarding select.
REQ-008 bdep  input  2  ID-stage B-operand forwarding select.
REQ-009 loaddep  input  1  ID-stage load-use stall flag.
REQ-010 btaken  input  1  ID-stage branch-taken flag.
REQ-011 arm  input  1  level; requests a capture.
REQ-012 trig_pc  input  32  trigger address.
REQ-013 stop  input  1  one-cycle pulse; ends capture early.
REQ-014 out_valid  output  1  head record available.
REQ-015 out_ready  input  1  host accepts head record.
REQ-016 out_data  output  72  head record {pc, inst, adep, bdep, loaddep, btaken, 2'b00}, MSB first.
REQ-017 state  output  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-018 count  output  PTR_W+1  records currently held.

Function
REQ-019 IDLE: nothing written; arm=1 SHALL move to ARMED next edge.
REQ-020 ARMED: arm=0 SHALL return to IDLE; pc==trig_pc (arm=1) SHALL write that cycle's sample and move to CAPTURE.
REQ-021 CAPTURE: one sample SHALL be written per cycle; after DEPTH samples total (trigger sample included) SHALL move to DONE.
REQ-022 stop=1 in CAPTURE SHALL move to DONE; the sample of the stop cycle SHALL NOT be written; stop ignored in other states.
REQ-023 DONE: no writes; when count==0 and arm==0 SHALL move to IDLE; with arm=1 at empty SHALL stay DONE until arm falls.
REQ-024 FIFO write at edge N SHALL make out_valid=1 from the cycle after edge N (one-cycle latency).
REQ-025 out_valid SHALL equal (count!=0); out_data SHALL be the oldest record, stable while out_valid=1 and out_ready=0.
REQ-026 Pop SHALL occur at the edge where out_valid=1 and out_ready=1; out_ready with out_valid=0 SHALL have no effect.
REQ-027 Simultaneous write and pop SHALL leave count unchanged and both SHALL take effect.
REQ-028 Pointers SHALL wrap modulo DEPTH; writes never exceed DEPTH per capture, so no overflow is possible; host may pop during CAPTURE.
REQ-029 Records not popped SHALL persist across DONE->IDLE->ARMED; a new capture SHALL write only into free entries and end at DEPTH writes or full, whichever first.

Reset
REQ-030 reset=1 SHALL immediately force state=IDLE, count=0, out_valid=0, both pointers=0, capture counter=0, dedup register cleared.
REQ-031 Reset mid-CAPTURE or mid-drain SHALL discard all stored records; out_data is don't-care while out_valid=0.
REQ-032 Storage array SHALL NOT require reset.

Configuration
REQ-033 Macro TRACE_DEDUP_EN defined: in CAPTURE a sample whose pc and inst both equal the last written record SHALL NOT be written nor counted toward DEPTH (collapses load-use stall repeats); trigger sample always written.
REQ-034 TRACE_DEDUP_EN undefined: every CAPTURE cycle SHALL be written; no dedup register synthesized.

Verification
REQ-035 Reset, arm=1, trig_pc=0x0000_0008, pc 0,4,8,C,... per cycle, out_ready=0 -> state 0->1->2->3; count=16; records pc 0x8..0x44 in order.
REQ-036 After REQ-035, out_ready=1 -> 16 pops, pcs 0x8..0x44, then out_valid=0, count=0; arm=0 -> state=IDLE.
REQ-037 Capture with out_ready=1 throughout -> count never exceeds 1; 16 records delivered; DONE then IDLE after arm=0.
REQ-038 stop pulsed on 4th CAPTURE cycle -> exactly 4 records (trigger + 3); state=DONE next edge.
REQ-039 pc=0x10 held 3 cycles with loaddep=1 after trigger -> TRACE_DEDUP_EN: one 0x10 record, 16 distinct; undefined: three 0x10 records with loaddep=1.
REQ-040 reset pulsed with count=9 mid-capture -> same cycle count=0, out_valid=0, state=IDLE; asserts clean restart.
